// File: rtl/vscale_src_a_shared_stage.sv
// Masked execute-stage operand-A select: picks PC, rs1 or zero and re-masks the result into fresh Boolean shares.
// Latency 1 cycle from accept to out_valid; stall holds the output register, kill invalidates it, and a missing rnd deasserts in_ready.
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`define SRC_A_RS1       2'd0
`define SRC_A_PC        2'd1
`define SRC_A_ZERO      2'd2
`endif

module vscale_src_a_shared_stage #(
    parameter int DWIDTH    = 32,
    parameter int SHARES    = 2,
    parameter bit REFRESH   = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [`SRC_A_SEL_WIDTH-1:0]   src_a_sel,
    input  logic [DWIDTH-1:0]             PC_EX,
    input  logic [SHARES*DWIDTH-1:0]      rs1_data_shares,
    input  logic [(SHARES-1)*DWIDTH-1:0]  rnd,
    input  logic                          rnd_valid,
    input  logic                          in_valid,
    input  logic                          stall,
    input  logic                          kill,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [SHARES*DWIDTH-1:0]      alu_src_a_shares,
    output logic [CNT_WIDTH-1:0]          rnd_starve_cnt
);

    logic                     sel_pc;
    logic                     sel_zero;
    logic                     sel_pub;
    logic                     need_rnd;
    logic                     accept;
    logic                     starve;
    logic [SHARES*DWIDTH-1:0] shares_d;
    logic [SHARES*DWIDTH-1:0] shares_q;
    logic                     valid_q;
    logic [CNT_WIDTH-1:0]     cnt_q;

    assign sel_pc   = (src_a_sel == `SRC_A_PC);
    assign sel_zero = (src_a_sel == `SRC_A_ZERO);
    assign sel_pub  = sel_pc || sel_zero;
    assign need_rnd = sel_pub || REFRESH;

    assign in_ready = !stall && !kill && (rnd_valid || !need_rnd);
    assign accept   = in_valid && in_ready;
    assign starve   = in_valid && !stall && !kill && need_rnd && !rnd_valid;

    // Public values enter as share 0 over zero upper shares; masking is then
    // identical for both paths: r_(j-1) onto share j, XOR of all r onto share 0.
    always_comb begin
        logic [DWIDTH-1:0] rnd_xor;
        logic [DWIDTH-1:0] base;
        rnd_xor = '0;
        for (int j = 0; j < SHARES-1; j++) begin
            rnd_xor = rnd_xor ^ rnd[j*DWIDTH +: DWIDTH];
        end
        shares_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            if (sel_pub) begin
                base = (i == 0 && sel_pc) ? PC_EX : '0;
            end else begin
                base = rs1_data_shares[i*DWIDTH +: DWIDTH];
            end
            if (!need_rnd) begin
                shares_d[i*DWIDTH +: DWIDTH] = base;
            end else if (i == 0) begin
                shares_d[i*DWIDTH +: DWIDTH] = base ^ rnd_xor;
            end else begin
                shares_d[i*DWIDTH +: DWIDTH] = base ^ rnd[(i-1)*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            shares_q <= '0;
        end else if (kill) begin
            valid_q  <= 1'b0;
        end else if (stall) begin
            valid_q  <= valid_q;
        end else if (accept) begin
            valid_q  <= 1'b1;
            shares_q <= shares_d;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (starve && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid        = valid_q;
    assign alu_src_a_shares = shares_q;
    assign rnd_starve_cnt   = cnt_q;

endmodule

// File: tb/tb_vscale_src_a_shared_stage.sv
// Directed bench for the masked operand-A stage: main instance plus a 2-bit-counter and a pass-through variant.
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`define SRC_A_RS1       2'd0
`define SRC_A_PC        2'd1
`define SRC_A_ZERO      2'd2
`endif

module tb_vscale_src_a_shared_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_a_sel = `SRC_A_RS1;
    logic [31:0] PC_EX = '0;
    logic [63:0] rs1_data_shares = '0;
    logic [31:0] rnd = '0;
    logic        rnd_valid = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        kill = 1'b0;

    logic        in_ready, out_valid;
    logic [63:0] shares;
    logic [15:0] cnt;
    logic        s_in_ready, s_out_valid;
    logic [63:0] s_shares;
    logic [1:0]  s_cnt;
    logic        n_in_ready, n_out_valid;
    logic [63:0] n_shares;
    logic [15:0] n_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vscale_src_a_shared_stage #(.DWIDTH(32), .SHARES(2), .REFRESH(1'b1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .src_a_sel(src_a_sel), .PC_EX(PC_EX),
        .rs1_data_shares(rs1_data_shares), .rnd(rnd), .rnd_valid(rnd_valid),
        .in_valid(in_valid), .stall(stall), .kill(kill), .in_ready(in_ready),
        .out_valid(out_valid), .alu_src_a_shares(shares), .rnd_starve_cnt(cnt)
    );

    vscale_src_a_shared_stage #(.DWIDTH(32), .SHARES(2), .REFRESH(1'b1), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .src_a_sel(src_a_sel), .PC_EX(PC_EX),
        .rs1_data_shares(rs1_data_shares), .rnd(rnd), .rnd_valid(rnd_valid),
        .in_valid(in_valid), .stall(stall), .kill(kill), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .alu_src_a_shares(s_shares), .rnd_starve_cnt(s_cnt)
    );

    vscale_src_a_shared_stage #(.DWIDTH(32), .SHARES(2), .REFRESH(1'b0), .CNT_WIDTH(16)) dut_nr (
        .clk(clk), .rst_n(rst_n), .src_a_sel(src_a_sel), .PC_EX(PC_EX),
        .rs1_data_shares(rs1_data_shares), .rnd(rnd), .rnd_valid(rnd_valid),
        .in_valid(in_valid), .stall(stall), .kill(kill), .in_ready(n_in_ready),
        .out_valid(n_out_valid), .alu_src_a_shares(n_shares), .rnd_starve_cnt(n_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        stall     = 1'b0;
        kill      = 1'b0;
        src_a_sel = `SRC_A_RS1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0 || shares !== 64'h0 || cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset: out_valid=%b shares=%h cnt=%0d want 0/0/0", out_valid, shares, cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pc_select();
        src_a_sel = `SRC_A_PC;
        PC_EX     = 32'h0000_1000;
        rnd       = 32'hA5A5_A5A5;
        rnd_valid = 1'b1;
        in_valid  = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL pc_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        // back-to-back second accept
        PC_EX = 32'h0000_0004;
        rnd   = 32'h0F0F_0000;
        #1;
        total++;
        if (out_valid !== 1'b1 || shares !== {32'hA5A5_A5A5, 32'hA5A5_B5A5}) begin
            bad++;
            $display("FAIL pc_select: out_valid=%b shares=%h want 1 a5a5a5a5a5a5b5a5", out_valid, shares);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || shares !== {32'h0F0F_0000, 32'h0F0F_0004}) begin
            bad++;
            $display("FAIL back_to_back: out_valid=%b shares=%h want 1 0f0f00000f0f0004", out_valid, shares);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_drop: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_rs1_refresh();
        src_a_sel       = `SRC_A_RS1;
        rs1_data_shares = {32'h0F0F_0F0F, 32'h1234_5678};
        rnd             = 32'hFFFF_0000;
        rnd_valid       = 1'b1;
        in_valid        = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (out_valid !== 1'b1 || shares !== {32'hF0F0_0F0F, 32'hEDCB_5678}) begin
            bad++;
            $display("FAIL rs1_refresh: out_valid=%b shares=%h want 1 f0f00f0fedcb5678", out_valid, shares);
        end
        total++;
        if ((shares[63:32] ^ shares[31:0]) !== 32'h1D3B_5977) begin
            bad++;
            $display("FAIL rs1_xor: xor=%h want 1d3b5977", shares[63:32] ^ shares[31:0]);
        end
        total++;
        if (n_out_valid !== 1'b1 || n_shares !== {32'h0F0F_0F0F, 32'h1234_5678}) begin
            bad++;
            $display("FAIL rs1_passthru: out_valid=%b shares=%h want 1 0f0f0f0f12345678", n_out_valid, n_shares);
        end
    endtask

    task automatic test_zero_starve();
        src_a_sel = `SRC_A_ZERO;
        rnd       = 32'h5555_AAAA;
        rnd_valid = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL zero_wait%0d: in_ready=%b want 0", i, in_ready);
            end
            tick();
        end
        rnd_valid = 1'b1;
        #1;
        total++;
        if (cnt !== 16'd3 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_starve: cnt=%0d in_ready=%b want 3 1", cnt, in_ready);
        end
        tick();
        idle();
        #1;
        total++;
        if (out_valid !== 1'b1 || shares !== {32'h5555_AAAA, 32'h5555_AAAA}) begin
            bad++;
            $display("FAIL zero_select: out_valid=%b shares=%h want 1 5555aaaa5555aaaa", out_valid, shares);
        end
    endtask

    task automatic test_stall_kill();
        src_a_sel = `SRC_A_PC;
        PC_EX     = 32'h0000_2000;
        rnd       = 32'h1111_1111;
        rnd_valid = 1'b1;
        in_valid  = 1'b1;
        tick();
        stall = 1'b1;
        PC_EX = 32'hDEAD_BEEF;
        rnd   = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready%0d: in_ready=%b want 0", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || shares !== {32'h1111_1111, 32'h1111_3111}) begin
                bad++;
                $display("FAIL stall_hold%0d: out_valid=%b shares=%h want 1 1111111111113111", i, out_valid, shares);
            end
        end
        kill = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || shares !== {32'h1111_1111, 32'h1111_3111}) begin
            bad++;
            $display("FAIL kill_stall: out_valid=%b shares=%h want 0 1111111111113111", out_valid, shares);
        end
        idle();
    endtask

    task automatic test_norefresh();
        test_reset();
        src_a_sel       = `SRC_A_RS1;
        rs1_data_shares = {32'hCAFE_0001, 32'h0BAD_F00D};
        rnd_valid       = 1'b0;
        in_valid        = 1'b1;
        #1;
        total++;
        if (n_in_ready !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL norefresh_ready: nr=%b main=%b want 1 0", n_in_ready, in_ready);
        end
        tick();
        idle();
        #1;
        total++;
        if (n_out_valid !== 1'b1 || n_shares !== {32'hCAFE_0001, 32'h0BAD_F00D} || n_cnt !== 16'd0) begin
            bad++;
            $display("FAIL norefresh_out: v=%b shares=%h cnt=%0d want 1 cafe00010badf00d 0", n_out_valid, n_shares, n_cnt);
        end
        total++;
        if (cnt !== 16'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL norefresh_main: cnt=%0d v=%b want 1 0", cnt, out_valid);
        end
    endtask

    task automatic test_saturation();
        test_reset();
        src_a_sel = `SRC_A_ZERO;
        rnd_valid = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        #1;
        total++;
        if (s_cnt !== 2'd3 || cnt !== 16'd5) begin
            bad++;
            $display("FAIL saturation: small=%0d main=%0d want 3 5", s_cnt, cnt);
        end
    endtask

    task automatic test_async_reset();
        src_a_sel = `SRC_A_PC;
        PC_EX     = 32'h0000_0100;
        rnd       = 32'h0000_00FF;
        rnd_valid = 1'b1;
        in_valid  = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || shares !== 64'h0 || cnt !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: v=%b shares=%h cnt=%0d want 0 0 0", out_valid, shares, cnt);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || shares !== {32'h0000_00FF, 32'h0000_01FF}) begin
            bad++;
            $display("FAIL post_reset_accept: v=%b shares=%h want 1 000000ff000001ff", out_valid, shares);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_pc_select();
        test_rs1_refresh();
        test_zero_starve();
        test_stall_kill();
        test_norefresh();
        test_saturation();
        test_async_reset();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vscale_src_a_shared_stage.md
# vscale_src_a_shared_stage

Registered, SHARES-way masked successor of the execute-stage ALU operand-A select in the DOM vscale pipeline. It picks PC, rs1 or zero for operand A and re-masks public values into fresh shares from the randomness port. It can also refresh the rs1 shares. Shares are never recombined inside the block. The result is held in a one-deep output register with stall/kill control, and the block counts cycles lost to missing randomness.

## Interface
- DWIDTH, 32, datapath width per share
- SHARES, 2, number of Boolean shares (≥2)
- REFRESH, 1, 1 = re-mask rs1 shares with fresh randomness; 0 = pass rs1 shares through
- CNT_WIDTH, 16, width of the randomness-starvation counter
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_a_sel  in  `SRC_A_SEL_WIDTH  `SRC_A_PC`, `SRC_A_ZERO`; any other code selects rs1
- PC_EX  in  DWIDTH  public PC of the execute instruction
- rs1_data_shares  in  SHARES*DWIDTH  rs1 shares; share i occupies bits [i*DWIDTH +: DWIDTH]
- rnd  in  (SHARES-1)*DWIDTH  fresh randomness, slice j = r_j
- rnd_valid  in  1  rnd is fresh this cycle
- in_valid  in  1  operand request valid
- stall  in  1  downstream stall; hold the output register
- kill  in  1  flush; invalidate the output register
- in_ready  out  1  request accepted this cycle
- out_valid  out  1  alu_src_a_shares valid
- alu_src_a_shares  out  SHARES*DWIDTH  registered operand-A shares
- rnd_starve_cnt  out  CNT_WIDTH  saturating count of randomness-starved cycles

## Operation
- Randomness is needed (need_rnd) when src_a_sel is PC, src_a_sel is ZERO, or (REFRESH=1 and rs1 is selected).
- in_ready = !stall && !kill && (rnd_valid || !need_rnd). The ready equation is combinational.
- Accept = in_valid && in_ready.
- Next shares for a PC or ZERO request, with v = PC_EX or 0:
  - share j = r_(j-1) for j = 1..SHARES-1
  - share 0 = v ^ r_0 ^ … ^ r_(SHARES-2)
- Next shares for an rs1 request with REFRESH=1:
  - share j = s_j ^ r_(j-1)
  - share 0 = s_0 ^ r_0 ^ … ^ r_(SHARES-2)
  - The XOR of all shares is unchanged.
- Next shares for an rs1 request with REFRESH=0: share i = s_i unmodified; rnd and rnd_valid are ignored.
- The XOR of all output shares always equals the selected value.
- Output register update, priority highest first:
  - kill: out_valid←0, shares held
  - stall: everything held
  - accept: shares←next, out_valid←1
  - otherwise: out_valid←0, shares held
- Starvation counter increments when in_valid && !stall && !kill && need_rnd && !rnd_valid. It saturates at all-ones and never wraps.
- A given rnd value must be used by at most one accept; the block does not check reuse.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, alu_src_a_shares=0, rnd_starve_cnt=0. in_ready still follows its combinational equation.
- Latency: 1 cycle from accept to out_valid and data.
- Throughput: one accept per cycle when not stalled and randomness is available.
- Kill and stall in the same cycle: kill wins, so out_valid drops.
- Stall with in_valid high: no accept, and the request must be re-presented.
- Reset deasserted mid-operation: the first accept can occur in the first cycle after deassertion.
- rs1 selected with REFRESH=0: in_ready is independent of rnd_valid, and the counter never increments.

## Test plan
All scenarios use SHARES=2, DWIDTH=32, REFRESH=1.
- PC select: PC_EX=0x0000_1000, rnd=0xA5A5_A5A5, rnd_valid=1 → next cycle out_valid=1, share1=0xA5A5_A5A5, share0=0xA5A5_B5A5.
- rs1 refresh: shares 0x1234_5678 and 0x0F0F_0F0F, rnd=0xFFFF_0000 → share1=0xF0F0_0F0F, share0=0xEDCB_5678; share XOR remains 0x1D3B_5977.
- ZERO select, rnd_valid=0 for 3 cycles then 1 → in_ready=0 for 3 cycles, rnd_starve_cnt=3; on the 4th cycle in_ready=1 and the output shares XOR to 0.
- Stall for 2 cycles after a valid output → shares and out_valid held; then kill with stall still high → out_valid=0 next cycle.
- Counter saturation with CNT_WIDTH=2: 5 starved cycles → rnd_starve_cnt=3.
- Asynchronous reset pulse between clock edges with out_valid=1 → out_valid=0 and shares=0 immediately, not waiting for an edge.
